// File: rtl/pmp_formal_pkg.sv
// rtl/pmp_formal_pkg.sv - shared types and constants for the fetch PMP/translation stage
package pmp_formal_pkg;

    localparam int unsigned XLEN_W  = 64;
    localparam int unsigned VLEN_W  = 64;
    localparam int unsigned PLEN_W  = 56;
    localparam int unsigned GPLEN_W = 41;

    localparam logic [XLEN_W-1:0] INSTR_ACCESS_FAULT = XLEN_W'(1);

    localparam logic [1:0] PRIV_LVL_M = 2'b11;

    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } pmp_a_t;

    localparam int unsigned PMPCFG_X     = 2;
    localparam int unsigned PMPCFG_A_LSB = 3;
    localparam int unsigned PMPCFG_L     = 7;

    typedef struct packed {
        logic [XLEN_W-1:0]  cause;
        logic [XLEN_W-1:0]  tval;
        logic [GPLEN_W-1:0] tval2;
        logic [31:0]        tinst;
        logic               gva;
        logic               valid;
    } exception_t;

    typedef struct packed {
        logic              fetch_req;
        logic [VLEN_W-1:0] fetch_vaddr;
    } icache_arsp_t;

    typedef struct packed {
        logic              fetch_valid;
        logic [PLEN_W-1:0] fetch_paddr;
        exception_t        fetch_exception;
    } icache_areq_t;

endpackage

// File: rtl/ifetch_pmp_xlat_if.sv
// rtl/ifetch_pmp_xlat_if.sv - I$ translation request/answer bundle
interface ifetch_pmp_xlat_if;
    import pmp_formal_pkg::*;

    icache_arsp_t arsp;
    icache_areq_t areq;

    modport master (output arsp, input areq);
    modport slave  (input arsp, output areq);
endinterface

// File: rtl/ifetch_pmp_check.sv
// rtl/ifetch_pmp_check.sv - combinational PMP execute-permission check
module ifetch_pmp_check
    import pmp_formal_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 8,
    parameter int unsigned PLEN       = 56,
    localparam int unsigned NE        = (NR_ENTRIES == 0) ? 1 : NR_ENTRIES,
    localparam int unsigned AW        = PLEN - 2
) (
    input  logic [PLEN-1:0]   paddr_i,
    input  logic [1:0]        priv_lvl_i,
    input  logic [8*NE-1:0]   cfg_i,
    input  logic [AW*NE-1:0]  addr_i,
    output logic              allow_o
);

    logic [AW-1:0] word_addr;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] napot_mask;
    logic          hit;
    logic          found;
    logic          lock;
    logic          xperm;
    logic          unused_cfg;

    assign word_addr  = paddr_i[PLEN-1:2];
    assign unused_cfg = ^{cfg_i, paddr_i[1:0]};

    // Walk from entry 0 upward so the lowest-index match sticks; prev_addr
    // carries the TOR lower bound from the previous entry.
    always_comb begin
        found      = 1'b0;
        lock       = 1'b0;
        xperm      = 1'b0;
        hit        = 1'b0;
        prev_addr  = '0;
        cur_addr   = '0;
        napot_mask = '0;
        for (int i = 0; i < int'(NE); i++) begin
            cur_addr   = addr_i[AW*i +: AW];
            napot_mask = cur_addr ^ (cur_addr + AW'(1));
            case (pmp_a_t'(cfg_i[8*i+PMPCFG_A_LSB +: 2]))
                PMP_TOR:   hit = (prev_addr < cur_addr) && (word_addr >= prev_addr) && (word_addr < cur_addr);
                PMP_NA4:   hit = (word_addr == cur_addr);
                PMP_NAPOT: hit = (((word_addr ^ cur_addr) & ~napot_mask) == '0);
                default:   hit = 1'b0;
            endcase
            if (hit && !found) begin
                found = 1'b1;
                lock  = cfg_i[8*i+PMPCFG_L];
                xperm = cfg_i[8*i+PMPCFG_X];
            end
            prev_addr = cur_addr;
        end
    end

    always_comb begin
        allow_o = 1'b0;
        if (NR_ENTRIES == 0) begin
            allow_o = 1'b1;
        end else if (priv_lvl_i == PRIV_LVL_M) begin
            allow_o = !(found && lock) || xperm;
        end else begin
            allow_o = found && xperm;
        end
    end

endmodule

// File: rtl/ifetch_pmp_xlat.sv
// rtl/ifetch_pmp_xlat.sv - bare-mode fetch translation with shadowed PMP check (option: IFETCH_PMP_FAULT_CNT_EN)
module ifetch_pmp_xlat
    import pmp_formal_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 8,
    parameter int unsigned XLEN       = XLEN_W,
    parameter int unsigned VLEN       = VLEN_W,
    parameter int unsigned PLEN       = PLEN_W,
    parameter int unsigned GPLEN      = GPLEN_W,
    localparam int unsigned NE        = (NR_ENTRIES == 0) ? 1 : NR_ENTRIES,
    localparam int unsigned AW        = PLEN - 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ifetch_pmp_xlat_if.slave    ic,
    input  logic                flush_i,
    input  logic [1:0]          priv_lvl_i,
    input  logic [8*NE-1:0]     pmpcfg_i,
    input  logic [AW*NE-1:0]    pmpaddr_i,
    input  logic                pmp_update_i,
    output logic                pmp_busy_o
`ifdef IFETCH_PMP_FAULT_CNT_EN
    ,
    output logic [15:0]         fault_cnt_o
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } upd_state_t;

    upd_state_t        state_q, state_d;
    logic              valid_q, valid_d;
    logic [PLEN-1:0]   paddr_q, paddr_d;
    exception_t        exc_q, exc_d;
    logic [8*NE-1:0]   sh_cfg_q, sh_cfg_d, buf_cfg_q, buf_cfg_d;
    logic [AW*NE-1:0]  sh_addr_q, sh_addr_d, buf_addr_q, buf_addr_d;
    logic [PLEN-1:0]   req_paddr;
    logic              req;
    logic              allow;
    logic              safe;

    assign req       = ic.arsp.fetch_req;
    assign req_paddr = ic.arsp.fetch_vaddr[PLEN-1:0];
    assign safe      = !req && !valid_q;

    ifetch_pmp_check #(
        .NR_ENTRIES (NR_ENTRIES),
        .PLEN       (PLEN)
    ) u_check (
        .paddr_i    (req_paddr),
        .priv_lvl_i (priv_lvl_i),
        .cfg_i      (sh_cfg_q),
        .addr_i     (sh_addr_q),
        .allow_o    (allow)
    );

    always_comb begin
        valid_d = req && !flush_i;
        paddr_d = paddr_q;
        exc_d   = exc_q;
        if (req) begin
            paddr_d = req_paddr;
            exc_d   = '0;
            if (!allow) begin
                exc_d.valid = 1'b1;
                exc_d.cause = XLEN'(INSTR_ACCESS_FAULT);
                exc_d.tval  = XLEN'(ic.arsp.fetch_vaddr[VLEN-1:0]);
                exc_d.tval2 = GPLEN'(0);
            end
        end
    end

    // The shadow only changes when nothing is in flight, so every request
    // sees one consistent configuration from check to response.
    always_comb begin
        state_d    = state_q;
        sh_cfg_d   = sh_cfg_q;
        sh_addr_d  = sh_addr_q;
        buf_cfg_d  = buf_cfg_q;
        buf_addr_d = buf_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (pmp_update_i) begin
                    if (safe) begin
                        sh_cfg_d  = pmpcfg_i;
                        sh_addr_d = pmpaddr_i;
                    end else begin
                        buf_cfg_d  = pmpcfg_i;
                        buf_addr_d = pmpaddr_i;
                        state_d    = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (safe) begin
                    sh_cfg_d  = pmp_update_i ? pmpcfg_i  : buf_cfg_q;
                    sh_addr_d = pmp_update_i ? pmpaddr_i : buf_addr_q;
                    state_d   = ST_IDLE;
                end else if (pmp_update_i) begin
                    buf_cfg_d  = pmpcfg_i;
                    buf_addr_d = pmpaddr_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            paddr_q    <= '0;
            exc_q      <= '0;
            sh_cfg_q   <= '0;
            sh_addr_q  <= '0;
            buf_cfg_q  <= '0;
            buf_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            paddr_q    <= paddr_d;
            exc_q      <= exc_d;
            sh_cfg_q   <= sh_cfg_d;
            sh_addr_q  <= sh_addr_d;
            buf_cfg_q  <= buf_cfg_d;
            buf_addr_q <= buf_addr_d;
        end
    end

    assign ic.areq.fetch_valid     = valid_q;
    assign ic.areq.fetch_paddr     = paddr_q;
    assign ic.areq.fetch_exception = exc_q;
    assign pmp_busy_o              = (state_q == ST_PEND);

`ifdef IFETCH_PMP_FAULT_CNT_EN
    logic [15:0] fault_cnt_q, fault_cnt_d;

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (valid_q && exc_q.valid && (fault_cnt_q != 16'hFFFF)) begin
            fault_cnt_d = fault_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault_cnt_o = fault_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_pmp_xlat.sv
// tb/tb_ifetch_pmp_xlat.sv - directed self-checking bench for ifetch_pmp_xlat
module tb_ifetch_pmp_xlat;
    import pmp_formal_pkg::*;

    localparam int unsigned NR = 8;
    localparam int unsigned AW = 54;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [1:0]        priv = 2'd0;
    logic [8*NR-1:0]   cfg_in = '0;
    logic [AW*NR-1:0]  addr_in = '0;
    logic              update = 1'b0;
    logic              busy;
    int                tests_run = 0;
    int                tests_failed = 0;
`ifdef IFETCH_PMP_FAULT_CNT_EN
    logic [15:0]       fault_cnt;
`endif

    ifetch_pmp_xlat_if ic ();

    ifetch_pmp_xlat #(.NR_ENTRIES(NR)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ic           (ic.slave),
        .flush_i      (flush),
        .priv_lvl_i   (priv),
        .pmpcfg_i     (cfg_in),
        .pmpaddr_i    (addr_in),
        .pmp_update_i (update),
        .pmp_busy_o   (busy)
`ifdef IFETCH_PMP_FAULT_CNT_EN
        ,
        .fault_cnt_o  (fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input string tag, input logic [63:0] va, input logic [1:0] pl, input bit fault);
        @(negedge clk);
        priv = pl;
        ic.arsp.fetch_req   = 1'b1;
        ic.arsp.fetch_vaddr = va;
        @(posedge clk); #1;
        ic.arsp.fetch_req = 1'b0;
        check_eq({tag, ".valid"}, 64'(ic.areq.fetch_valid), 64'd1);
        check_eq({tag, ".paddr"}, 64'(ic.areq.fetch_paddr), {8'h0, va[55:0]});
        check_eq({tag, ".exc"},   64'(ic.areq.fetch_exception.valid), fault ? 64'd1 : 64'd0);
        check_eq({tag, ".cause"}, ic.areq.fetch_exception.cause, fault ? 64'd1 : 64'd0);
        check_eq({tag, ".tval"},  ic.areq.fetch_exception.tval, fault ? va : 64'd0);
        check_eq({tag, ".rest"},  64'(|{ic.areq.fetch_exception.tval2, ic.areq.fetch_exception.tinst,
                                       ic.areq.fetch_exception.gva}), 64'd0);
        @(posedge clk); #1;
        check_eq({tag, ".pulse"}, 64'(ic.areq.fetch_valid), 64'd0);
    endtask

    task automatic pmp_write(input string tag);
        @(negedge clk);
        update = 1'b1;
        @(posedge clk); #1;
        update = 1'b0;
        check_eq({tag, ".busy"}, 64'(busy), 64'd0);
    endtask

    logic [63:0] b2b_va [3];
    bit          b2b_ft [3];

    initial begin
        ic.arsp = '0;
        b2b_va[0] = 64'h8000_0000; b2b_ft[0] = 1'b0;
        b2b_va[1] = 64'h8000_1000; b2b_ft[1] = 1'b1;
        b2b_va[2] = 64'h8000_0004; b2b_ft[2] = 1'b0;

        @(posedge clk); #1;
        check_eq("rst.valid", 64'(ic.areq.fetch_valid), 64'd0);
        check_eq("rst.paddr", 64'(ic.areq.fetch_paddr), 64'd0);
        check_eq("rst.busy",  64'(busy), 64'd0);
        @(negedge clk); rst = 1'b0;

        do_fetch("off_u", 64'h8000_0000, 2'd0, 1'b1);
        do_fetch("off_m", 64'h8000_0000, 2'd3, 1'b0);

        // Entry 0 NAPOT 0x2000_0FFF covers bytes 0x8000_0000..0x8000_7FFF.
        cfg_in = '0; addr_in = '0;
        cfg_in[7:0] = 8'h99; addr_in[AW-1:0] = AW'(64'h2000_0FFF);
        pmp_write("wr_napot_l");
        do_fetch("napot_m_in",  64'h8000_1000, 2'd3, 1'b1);
        do_fetch("napot_m_top", 64'h8000_7FFC, 2'd3, 1'b1);
        do_fetch("napot_m_out", 64'h8000_8000, 2'd3, 1'b0);

        cfg_in[7:0] = 8'h19;
        pmp_write("wr_napot_nl");
        do_fetch("napot_nl_m", 64'h8000_1000, 2'd3, 1'b0);
        do_fetch("napot_nl_s", 64'h8000_1000, 2'd1, 1'b1);

        cfg_in = '0; addr_in = '0;
        addr_in[AW-1:0]      = AW'(64'h2000_0000);
        cfg_in[15:8]         = 8'h0D;
        addr_in[2*AW-1:AW]   = AW'(64'h2000_0400);
        cfg_in[23:16]        = 8'h15;
        addr_in[3*AW-1:2*AW] = AW'(64'h2000_1000);
        pmp_write("wr_tor");
        do_fetch("tor_s_last", 64'h8000_0FFC, 2'd1, 1'b0);
        do_fetch("tor_s_end",  64'h8000_1000, 2'd1, 1'b1);
        do_fetch("tor_s_low",  64'h8000_0000, 2'd1, 1'b0);
        do_fetch("tor_u_below", 64'h7FFF_FFFC, 2'd0, 1'b1);
        do_fetch("tor_p2_in",  64'h8000_0800, 2'd2, 1'b0);
        do_fetch("na4_s_hit",  64'h8000_4000, 2'd1, 1'b0);
        do_fetch("na4_s_miss", 64'h8000_4004, 2'd1, 1'b1);

        for (int pass = 0; pass < 2; pass++) begin
            priv = 2'd1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                ic.arsp.fetch_req   = 1'b1;
                ic.arsp.fetch_vaddr = b2b_va[i];
                flush = (pass == 1) && (i == 1);
                @(posedge clk); #1;
                if ((pass == 1) && (i == 1)) begin
                    check_eq($sformatf("flush%0d.valid", i), 64'(ic.areq.fetch_valid), 64'd0);
                end else begin
                    check_eq($sformatf("b2b%0d_%0d.valid", pass, i), 64'(ic.areq.fetch_valid), 64'd1);
                    check_eq($sformatf("b2b%0d_%0d.paddr", pass, i), 64'(ic.areq.fetch_paddr), b2b_va[i]);
                    check_eq($sformatf("b2b%0d_%0d.exc", pass, i),
                             64'(ic.areq.fetch_exception.valid), 64'(b2b_ft[i]));
                end
            end
            @(negedge clk);
            ic.arsp.fetch_req = 1'b0;
            flush = 1'b0;
            @(posedge clk); #1;
            check_eq($sformatf("b2b%0d.end", pass), 64'(ic.areq.fetch_valid), 64'd0);
        end

        cfg_in = '0; addr_in = '0;
        pmp_write("wr_off");
        priv = 2'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ic.arsp.fetch_req   = 1'b1;
            ic.arsp.fetch_vaddr = 64'h8000_0000 + 64'(4 * i);
            if (i == 1) begin
                update = 1'b1;
                cfg_in[7:0] = 8'h1D;
                addr_in[AW-1:0] = {AW{1'b1}};
            end
            @(posedge clk); #1;
            update = 1'b0;
            cfg_in = '0; addr_in = '0;
            check_eq($sformatf("pend%0d.exc", i), 64'(ic.areq.fetch_exception.valid), 64'd1);
            if (i >= 1) check_eq($sformatf("pend%0d.busy", i), 64'(busy), 64'd1);
        end
        @(negedge clk);
        ic.arsp.fetch_req = 1'b0;
        @(posedge clk); #1;
        check_eq("pend_drain.busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check_eq("pend_load.busy", 64'(busy), 64'd0);
        do_fetch("pend_new_cfg", 64'h1234_5678, 2'd1, 1'b0);

        @(negedge clk);
        ic.arsp.fetch_req   = 1'b1;
        ic.arsp.fetch_vaddr = 64'h8000_0000;
        update = 1'b1;
        @(posedge clk); #1;
        ic.arsp.fetch_req = 1'b0;
        update = 1'b0;
        check_eq("prerst.busy",  64'(busy), 64'd1);
        check_eq("prerst.valid", 64'(ic.areq.fetch_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("arst.valid", 64'(ic.areq.fetch_valid), 64'd0);
        check_eq("arst.paddr", 64'(ic.areq.fetch_paddr), 64'd0);
        check_eq("arst.cause", ic.areq.fetch_exception.cause, 64'd0);
        check_eq("arst.busy",  64'(busy), 64'd0);
        @(negedge clk); rst = 1'b0;
        do_fetch("postrst_s", 64'h8000_0000, 2'd1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
